// File: rtl/spi_device_if.sv
// spi_device_if: local byte-side handshake bundle for spi_device.
// Signal suffixes are from the device's point of view (_o driven by the
// device, _i driven by the local host logic).
// Handshake: a word moves when valid and ready are both high at a clock edge;
// valid, once raised, holds its data stable until that edge.
interface spi_device_if #(
    parameter int unsigned DataWidth = 8
) ();
    logic [DataWidth-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic [DataWidth-1:0] tx_data_i;
    logic                 tx_valid_i;
    logic                 tx_ready_o;
    logic                 rx_overflow_o;
    logic                 tx_underrun_o;

    // Device side
    modport slave (
        output rx_data_o, rx_valid_o, tx_ready_o, rx_overflow_o, tx_underrun_o,
        input  rx_ready_i, tx_data_i, tx_valid_i
    );

    // Local host side
    modport master (
        input  rx_data_o, rx_valid_o, tx_ready_o, rx_overflow_o, tx_underrun_o,
        output rx_ready_i, tx_data_i, tx_valid_i
    );
endinterface

// File: rtl/spi_device.sv
// spi_device: SPI target endpoint. SCK/CS/COPI are oversampled in clk_sys_i,
// full-duplex words are exchanged with a local valid/ready byte interface.
// Optional macro SPI_DEVICE_MODE_CFG_EN adds cpol_i/cpha_i for all four SPI
// modes; without it the block is fixed to mode 0.
// Byte interface handshake: a word moves when valid and ready are both high at
// a clk_sys_i edge; rx_valid_o holds rx_data_o stable until accepted.
module spi_device #(
    parameter int unsigned          DataWidth  = 8,
    parameter logic [DataWidth-1:0] FillByte   = 8'hFF,
    parameter int unsigned          SyncStages = 2
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_ni,
    input  logic        spi_sck_i,
    input  logic        spi_cs_ni,
    input  logic        spi_copi_i,
`ifdef SPI_DEVICE_MODE_CFG_EN
    input  logic        cpol_i,
    input  logic        cpha_i,
`endif
    output logic        spi_cipo_o,
    output logic        spi_cipo_en_o,
    output logic        active_o,
    spi_device_if.slave bus_if
);

    localparam int unsigned CntW = $clog2(DataWidth + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DataWidth);
    localparam logic [CntW-1:0] CntLast = CntW'(DataWidth - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [SyncStages-1:0] sck_sync_q, cs_sync_q, copi_sync_q;
    logic                 sck_prev_q, cs_prev_q;
    logic [DataWidth-1:0] tx_shift_q, tx_shift_d;
    logic [DataWidth-1:0] rx_shift_q, rx_shift_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 cipo_q, cipo_d;
    logic                 cipo_en_q, cipo_en_d;
    logic                 first_q, first_d;
    logic [DataWidth-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ovf_q, rx_ovf_d;
    logic                 tx_unr_q, tx_unr_d;
    logic [DataWidth-1:0] tx_buf_q, tx_buf_d;
    logic                 tx_full_q, tx_full_d;

    logic sck_s, cs_s, copi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic cpol_s, cpha_s;
    logic lead_edge, trail_edge, smp_edge, upd_edge;
    logic do_load, word_done, rx_accept;
    logic [DataWidth-1:0] load_word;
    logic [DataWidth-1:0] rx_word;

    assign sck_s  = sck_sync_q[SyncStages-1];
    assign cs_s   = cs_sync_q[SyncStages-1];
    assign copi_s = copi_sync_q[SyncStages-1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

`ifdef SPI_DEVICE_MODE_CFG_EN
    logic cpol_q, cpha_q;

    // Mode bits are only taken while idle so a transfer never changes mode midway
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else if (state_q == IDLE) begin
            cpol_q <= cpol_i;
            cpha_q <= cpha_i;
        end
    end

    assign cpol_s = cpol_q;
    assign cpha_s = cpha_q;
`else
    assign cpol_s = 1'b0;
    assign cpha_s = 1'b0;
`endif

    // Leading edge leaves the SCK idle level; CPHA picks which edge samples
    assign lead_edge  = cpol_s ? sck_fall : sck_rise;
    assign trail_edge = cpol_s ? sck_rise : sck_fall;
    assign smp_edge   = cpha_s ? trail_edge : lead_edge;
    assign upd_edge   = cpha_s ? lead_edge : trail_edge;

    // Word taken at each TX load: buffered word, else same-cycle bypass, else fill
    assign load_word = tx_full_q          ? tx_buf_q :
                       bus_if.tx_valid_i  ? bus_if.tx_data_i : FillByte;

    assign rx_word   = {rx_shift_q[DataWidth-2:0], copi_s};
    assign rx_accept = rx_valid_q & bus_if.rx_ready_i;

    // Synchronisers, edge-detect history and all registered state
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            copi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            cipo_q      <= 1'b0;
            cipo_en_q   <= 1'b0;
            first_q     <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_unr_q    <= 1'b0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SyncStages-2:0], spi_sck_i};
            cs_sync_q   <= {cs_sync_q[SyncStages-2:0], spi_cs_ni};
            copi_sync_q <= {copi_sync_q[SyncStages-2:0], spi_copi_i};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            cipo_q      <= cipo_d;
            cipo_en_q   <= cipo_en_d;
            first_q     <= first_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_unr_q    <= tx_unr_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
        end
    end

    // FSM next state plus shifter, TX buffer and RX handshake updates
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        cipo_d     = cipo_q;
        cipo_en_d  = cipo_en_q;
        first_d    = first_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ovf_d   = 1'b0;
        tx_unr_d   = 1'b0;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        do_load    = 1'b0;
        word_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    do_load    = 1'b1;
                    tx_shift_d = load_word;
                    // With CPHA=1 the MSB waits for the first leading edge
                    cipo_d     = cpha_s ? 1'b0 : load_word[DataWidth-1];
                    cipo_en_d  = 1'b1;
                    bit_cnt_d  = '0;
                    first_d    = cpha_s;
                    rx_shift_d = '0;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    // Deselect wins over any SCK edge seen in the same cycle
                    state_d   = IDLE;
                    cipo_d    = 1'b0;
                    cipo_en_d = 1'b0;
                    bit_cnt_d = '0;
                    first_d   = 1'b0;
                end else begin
                    if (smp_edge && (bit_cnt_q != CntFull)) begin
                        rx_shift_d = rx_word;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        word_done  = (bit_cnt_q == CntLast);
                    end
                    if (upd_edge) begin
                        if (first_q) begin
                            cipo_d  = tx_shift_q[DataWidth-1];
                            first_d = 1'b0;
                        end else if (bit_cnt_q == CntFull) begin
                            do_load    = 1'b1;
                            tx_shift_d = load_word;
                            cipo_d     = load_word[DataWidth-1];
                            bit_cnt_d  = '0;
                        end else begin
                            tx_shift_d = tx_shift_q << 1;
                            cipo_d     = tx_shift_q[DataWidth-2];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // TX buffer: drained by a load, filled by a handshake that was not bypassed
        if (do_load) begin
            if (tx_full_q) begin
                tx_full_d = 1'b0;
            end else if (!bus_if.tx_valid_i) begin
                tx_unr_d = 1'b1;
            end
        end
        if (bus_if.tx_valid_i && !tx_full_q && !do_load) begin
            tx_buf_d  = bus_if.tx_data_i;
            tx_full_d = 1'b1;
        end

        // RX holding register: acceptance frees it in time for a same-cycle word
        if (rx_accept) begin
            rx_valid_d = 1'b0;
        end
        if (word_done) begin
            if (!rx_valid_q || rx_accept) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovf_d = 1'b1;
            end
        end
    end

    assign spi_cipo_o           = cipo_q;
    assign spi_cipo_en_o        = cipo_en_q;
    assign active_o             = (state_q == ACTIVE);
    assign bus_if.rx_data_o     = rx_data_q;
    assign bus_if.rx_valid_o    = rx_valid_q;
    assign bus_if.tx_ready_o    = ~tx_full_q;
    assign bus_if.rx_overflow_o = rx_ovf_q;
    assign bus_if.tx_underrun_o = tx_unr_q;

endmodule

// File: tb/tb_spi_device.sv
// tb_spi_device: directed bench for spi_device in mode 0. The bench acts as
// SPI controller (SCK = clk/8, pins changed on clk falling edges) and as the
// local byte-side host.
module tb_spi_device;

    logic clk;
    logic rst_n;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_copi;
    logic spi_cipo;
    logic spi_cipo_en;
    logic active;

    int n_checks = 0;
    int n_pass   = 0;
    int n_unr    = 0;
    int n_ovf    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    spi_device_if #(.DataWidth(8)) bus ();

    spi_device dut (
        .clk_sys_i     (clk),
        .rst_sys_ni    (rst_n),
        .spi_sck_i     (spi_sck),
        .spi_cs_ni     (spi_cs_n),
        .spi_copi_i    (spi_copi),
`ifdef SPI_DEVICE_MODE_CFG_EN
        .cpol_i        (1'b0),
        .cpha_i        (1'b0),
`endif
        .spi_cipo_o    (spi_cipo),
        .spi_cipo_en_o (spi_cipo_en),
        .active_o      (active),
        .bus_if        (bus.slave)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: accepted RX words and pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.rx_valid_o && bus.rx_ready_i) got_q.push_back(bus.rx_data_o);
        if (bus.tx_underrun_o) n_unr++;
        if (bus.rx_overflow_o) n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Compare every accepted RX word against the expected queue
    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check({tag, "_rx_word"}, got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic tx_preload(input logic [7:0] data);
        @(negedge clk);
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = data;
        @(negedge clk);
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic cs_start();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Shift nbits of mosi (MSB first); with end_cs, CS rises with the last SCK fall
    task automatic spi_word(input logic [7:0] mosi, input bit end_cs, input int nbits,
                            output logic [7:0] miso);
        miso = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_copi = mosi[i];
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            miso[i] = spi_cipo;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
            if (end_cs && (i == 8 - nbits)) spi_cs_n = 1'b1;
        end
        if (end_cs) repeat (8) @(negedge clk);
    endtask

    logic [7:0] miso;
    int unr0;
    int ovf0;

    initial begin
        rst_n          = 1'b0;
        spi_sck        = 1'b0;
        spi_cs_n       = 1'b1;
        spi_copi       = 1'b0;
        bus.rx_ready_i = 1'b1;
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_rx_valid", bus.rx_valid_o, 1'b0);
        check("rst_rx_data", bus.rx_data_o, 8'h00);
        check("rst_tx_ready", bus.tx_ready_o, 1'b1);
        check("rst_cipo_en", spi_cipo_en, 1'b0);
        check("rst_cipo", spi_cipo, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_flags", {bus.rx_overflow_o, bus.tx_underrun_o}, 2'b00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // One word: COPI A5, TX preloaded 3C
        unr0 = n_unr;
        tx_preload(8'h3C);
        check("t1_tx_full", bus.tx_ready_o, 1'b0);
        cs_start();
        check("t1_active", active, 1'b1);
        check("t1_cipo_en", spi_cipo_en, 1'b1);
        check("t1_tx_drained", bus.tx_ready_o, 1'b1);
        exp_q.push_back(8'hA5);
        spi_word(8'hA5, 1'b1, 8, miso);
        check("t1_cipo", miso, 8'h3C);
        check("t1_underrun", n_unr - unr0, 0);
        check("t1_idle", {active, spi_cipo_en}, 2'b00);
        check_rx("t1");

        // Three-word burst, nothing to send
        unr0 = n_unr;
        ovf0 = n_ovf;
        cs_start();
        exp_q.push_back(8'h12);
        spi_word(8'h12, 1'b0, 8, miso);
        check("t2_cipo0", miso, 8'hFF);
        exp_q.push_back(8'h34);
        spi_word(8'h34, 1'b0, 8, miso);
        check("t2_cipo1", miso, 8'hFF);
        exp_q.push_back(8'h56);
        spi_word(8'h56, 1'b1, 8, miso);
        check("t2_cipo2", miso, 8'hFF);
        check("t2_underrun", n_unr - unr0, 3);
        check("t2_overflow", n_ovf - ovf0, 0);
        check_rx("t2");

        // Two words with the consumer stalled
        ovf0 = n_ovf;
        bus.rx_ready_i = 1'b0;
        cs_start();
        spi_word(8'h9C, 1'b0, 8, miso);
        spi_word(8'h27, 1'b1, 8, miso);
        check("t3_overflow", n_ovf - ovf0, 1);
        check("t3_rx_valid", bus.rx_valid_o, 1'b1);
        check("t3_rx_data", bus.rx_data_o, 8'h9C);
        @(posedge clk);
        #1 bus.rx_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_rx_dropped", bus.rx_valid_o, 1'b0);
        exp_q.push_back(8'h9C);
        check_rx("t3");

        // Deselect after five bits, then a clean word
        cs_start();
        spi_word(8'hF0, 1'b1, 5, miso);
        check("t4_idle", {active, spi_cipo_en, spi_cipo}, 3'b000);
        check("t4_no_valid", bus.rx_valid_o, 1'b0);
        check_rx("t4_partial");
        cs_start();
        exp_q.push_back(8'h81);
        spi_word(8'h81, 1'b1, 8, miso);
        check_rx("t4");

        // tx_valid raised exactly in the CS-fall load cycle
        unr0 = n_unr;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.tx_valid_i = 1'b1;
        bus.tx_data_i  = 8'h5A;
        @(negedge clk);
        bus.tx_valid_i = 1'b0;
        check("t5_bypass_ready", bus.tx_ready_o, 1'b1);
        repeat (6) @(negedge clk);
        exp_q.push_back(8'h00);
        spi_word(8'h00, 1'b1, 8, miso);
        check("t5_cipo", miso, 8'h5A);
        check("t5_underrun", n_unr - unr0, 0);
        check_rx("t5");

        // Reset in the middle of a word, then a normal transfer
        tx_preload(8'h3C);
        tx_preload(8'h99);
        cs_start();
        spi_word(8'hC3, 1'b0, 4, miso);
        @(negedge clk);
        rst_n    = 1'b0;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_copi = 1'b0;
        @(negedge clk);
        check("t6_rst_outs", {active, spi_cipo_en, spi_cipo, bus.rx_valid_o}, 4'b0000);
        check("t6_rst_tx_ready", bus.tx_ready_o, 1'b1);
        check("t6_rst_flags", {bus.rx_overflow_o, bus.tx_underrun_o}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        got_q.delete();
        cs_start();
        exp_q.push_back(8'hC3);
        spi_word(8'hC3, 1'b1, 8, miso);
        check("t6_cipo_fill", miso, 8'hFF);
        check_rx("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
